// File: rtl/lamp_pkg.sv
// Shared types and helpers for the lamp PWM output stage.
// Fade behaviour is selected by the LAMP_FADE_EN macro.
package lamp_pkg;

  typedef enum logic [1:0] {
    OFF,
    FADE_IN,
    ON,
    FADE_OUT
  } lamp_state_t;

  function automatic int max_level(int bits);
    return (1 << bits) - 1;
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM counter and registered comparator.
// Full and zero levels are forced so the lamp never glitches at the ends.
module pwm_gen
  import lamp_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] level,
  output logic                pwm_out
);

  localparam logic [PWM_BITS-1:0] MAX =
    PWM_BITS'(max_level(PWM_BITS));

  logic [PWM_BITS-1:0] pwm_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_cnt <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (level == MAX)
        pwm_out <= 1'b1;
      else if (level == '0)
        pwm_out <= 1'b0;
      else
        pwm_out <= (pwm_cnt < level);
    end
  end

endmodule

// File: rtl/lamp_fade_pwm.sv
// Lamp driver: soft fade FSM plus PWM output.
// Define LAMP_FADE_EN for linear fades; otherwise the lamp switches hard.
module lamp_fade_pwm
  import lamp_pkg::*;
#(
  parameter int PWM_BITS     = 8,
  parameter int FADE_STEP_MS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick_1khz,
  input  logic                saida,
  output logic                pwm_out,
  output logic [PWM_BITS-1:0] level,
  output logic                busy
);

  localparam logic [PWM_BITS-1:0] MAX =
    PWM_BITS'(max_level(PWM_BITS));

`ifdef LAMP_FADE_EN
  localparam int SW =
    (FADE_STEP_MS > 1) ? $clog2(FADE_STEP_MS) : 1;
  localparam logic [SW-1:0] LAST =
    SW'(FADE_STEP_MS - 1);

  lamp_state_t   state;
  logic [SW-1:0] step;

  // A reversal keeps the current level; only the step phase restarts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= OFF;
      level <= '0;
      step  <= '0;
    end else begin
      unique case (state)
        OFF: begin
          if (saida) begin
            state <= FADE_IN;
            step  <= '0;
          end
        end
        FADE_IN: begin
          if (!saida) begin
            state <= FADE_OUT;
            step  <= '0;
          end else if (level == MAX) begin
            state <= ON;
            step  <= '0;
          end else if (tick_1khz) begin
            if (step == LAST) begin
              step  <= '0;
              level <= level + 1'b1;
            end else begin
              step <= step + 1'b1;
            end
          end
        end
        ON: begin
          if (!saida) begin
            state <= FADE_OUT;
            step  <= '0;
          end
        end
        FADE_OUT: begin
          if (saida) begin
            state <= FADE_IN;
            step  <= '0;
          end else if (level == '0) begin
            state <= OFF;
            step  <= '0;
          end else if (tick_1khz) begin
            if (step == LAST) begin
              step  <= '0;
              level <= level - 1'b1;
            end else begin
              step <= step + 1'b1;
            end
          end
        end
        default: begin
          state <= OFF;
          level <= '0;
          step  <= '0;
        end
      endcase
    end
  end

  assign busy = (state == FADE_IN) ||
                (state == FADE_OUT);
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      level <= '0;
    else
      level <= saida ? MAX : '0;
  end

  assign busy = 1'b0;
`endif

  pwm_gen #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .clk    (clk),
    .rst    (rst),
    .level  (level),
    .pwm_out(pwm_out)
  );

endmodule
